ram_arbiter: RTL
================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter: ADDR_W, 20, SRAM word-address width.
REQ-002 Clock and reset are one clock; reset is synchronous and active-high (clk, rst).
REQ-003 Port: clk  in  1  system clock; all state updates on rising edge.
REQ-004 Port: rst  in  1  synchronous active-high reset.
REQ-005 Port: if_ce_i  in  1  instruction-fetch read request.
REQ-006 Port: if_addr_i  in  32  fetch byte address.
REQ-007 Port: if_data_o  out  32  registered fetch data.
REQ-008 Port: mem_ce_i / mem_we_i  in  1 / 1  data-access request / write qualifier.
REQ-009 Port: mem_addr_i / mem_sel_i / mem_data_i  in  32 / 4 / 32  data byte address / active-high byte lanes / write data.
REQ-010 Port: mem_data_o  out  32  registered load data.
REQ-011 Port: stall_o  out  1  pipeline stall request, combinational.
REQ-012 Port: sram_addr_o / sram_be_n_o  out  ADDR_W / 4  word address = addr[ADDR_W+1:2] / active-low byte enables.
REQ-013 Port: sram_ce_n_o / sram_oe_n_o / sram_we_n_o  out  1 each  active-low SRAM strobes, registered.
REQ-014 Port: sram_dout_o / sram_dout_en_o / sram_din_i  out 32 / out 1 / in 32  write data / data-bus drive enable / read data.

Function
REQ-015 States: IDLE, RD1, RD2, WR1, WR2, WR3; one access in flight at a time.
REQ-016 Flags mem_served, if_served record completion of the current pipeline request.
REQ-017 stall_o = (mem_ce_i & ~mem_served) | (if_ce_i & ~if_served).
REQ-018 IDLE priority: pending MEM write -> WR1; else pending MEM read -> RD1 (owner MEM); else pending IF -> RD1 (owner IF); else stay.
REQ-019 RD1: address driven, ce_n=0, oe_n=0, we_n=1, dout_en=0; -> RD2.
REQ-020 RD2: sram_din_i captured into owner's data register, owner's served flag set; -> IDLE.
REQ-021 WR1: address, dout, be_n=~mem_sel_i, dout_en=1, ce_n=0, we_n=1; -> WR2. WR2: we_n=0; -> WR3. WR3: we_n=1, dout_en held, mem_served set; -> IDLE.
REQ-022 IF reads use be_n=4'b0000; IDLE drives all strobes 1 and dout_en 0.
REQ-023 Latency: isolated read stalls 2 cycles; isolated write stalls 3 cycles; MEM+IF together stall 2+1+2 (read) or 3+1+2 (write).
REQ-024 Both served flags clear on any edge where stall_o=0 (pipeline advances).
REQ-025 if_data_o and mem_data_o hold last captured value until overwritten.
REQ-026 A started access always completes, even if its ce drops mid-access; its flag is still set.
REQ-027 IF never preempts MEM; MEM never waits behind an IF access not yet started.

Reset
REQ-028 On rst: state IDLE, both flags 0, if_data_o=0, mem_data_o=0, all SRAM strobes 1, be_n 4'hF, dout_en 0, sram_addr_o 0, sram_dout_o 0.
REQ-029 rst mid-access aborts it at that edge; no served flag is set.

Configuration
REQ-030 Macro SRAM_WAIT_STATE_EN: when defined, one extra RD1-like cycle precedes RD2 and WR2 lasts two cycles (read stall 3, write stall 4); when undefined, timing per REQ-019..023.

Verification
REQ-031 IF read only, addr 0x0000_0010, sram_din_i=0xDEADBEEF -> sram_addr_o=4, stall_o high 2 cycles, if_data_o=0xDEADBEEF.
REQ-032 MEM write addr 0x20, sel 4'b0011, data 0x12345678 -> be_n=4'b1100, we_n low exactly 1 cycle (WR2), dout_en high WR1..WR3, stall 3 cycles.
REQ-033 MEM read 0x40 + IF read 0x44 same cycle -> MEM served first, sram_addr_o 16 then 17, stall_o high 5 cycles, both data registers correct.
REQ-034 rst asserted in WR2 -> next cycle IDLE, we_n=1, dout_en=0, flags 0, stall_o re-asserted while requests remain.
REQ-035 With SRAM_WAIT_STATE_EN defined, repeat REQ-031/032 -> stall 3 and 4 cycles, we_n low 2 cycles.

Source files
------------

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one asynchronous 32-bit SRAM between instruction fetch and data access.
// Build option: define SRAM_WAIT_STATE_EN for one extra read cycle and a two-cycle write pulse.

module ram_arbiter #(
  parameter int ADDR_W = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_ce_i,
  input  logic [31:0]       if_addr_i,
  output logic [31:0]       if_data_o,
  input  logic              mem_ce_i,
  input  logic              mem_we_i,
  input  logic [31:0]       mem_addr_i,
  input  logic [3:0]        mem_sel_i,
  input  logic [31:0]       mem_data_i,
  output logic [31:0]       mem_data_o,
  output logic              stall_o,
  output logic [ADDR_W-1:0] sram_addr_o,
  output logic [3:0]        sram_be_n_o,
  output logic              sram_ce_n_o,
  output logic              sram_oe_n_o,
  output logic              sram_we_n_o,
  output logic [31:0]       sram_dout_o,
  output logic              sram_dout_en_o,
  input  logic [31:0]       sram_din_i
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD1  = 3'd1,
    S_RD2  = 3'd2,
    S_WR1  = 3'd3,
    S_WR2  = 3'd4,
    S_WR3  = 3'd5,
    S_RDW  = 3'd6,
    S_WRW  = 3'd7
  } state_t;

  state_t            r_state;
  logic              r_owner_mem;
  logic              r_mem_served;
  logic              r_if_served;
  logic [31:0]       r_if_data;
  logic [31:0]       r_mem_data;
  logic [ADDR_W-1:0] r_sram_addr;
  logic [3:0]        r_sram_be_n;
  logic              r_sram_ce_n;
  logic              r_sram_oe_n;
  logic              r_sram_we_n;
  logic [31:0]       r_sram_dout;
  logic              r_sram_dout_en;

  logic w_mem_pend;
  logic w_if_pend;
  logic w_stall;
  logic w_rd_last;
  logic w_wr_last;
  logic w_unused;

  assign w_mem_pend = mem_ce_i & ~r_mem_served;
  assign w_if_pend  = if_ce_i & ~r_if_served;
  assign w_stall    = w_mem_pend | w_if_pend;

  // The last read cycle captures data; the last write-pulse cycle releases we_n.
`ifdef SRAM_WAIT_STATE_EN
  assign w_rd_last = (r_state == S_RDW);
  assign w_wr_last = (r_state == S_WRW);
`else
  assign w_rd_last = (r_state == S_RD1);
  assign w_wr_last = (r_state == S_WR2);
`endif

  assign w_unused = ^{mem_addr_i[31:ADDR_W+2], mem_addr_i[1:0],
                      if_addr_i[31:ADDR_W+2], if_addr_i[1:0]};

  // Access sequencer: state, served flags, captured data and all SRAM strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_owner_mem    <= 1'b0;
      r_mem_served   <= 1'b0;
      r_if_served    <= 1'b0;
      r_if_data      <= 32'h0000_0000;
      r_mem_data     <= 32'h0000_0000;
      r_sram_addr    <= {ADDR_W{1'b0}};
      r_sram_be_n    <= 4'hF;
      r_sram_ce_n    <= 1'b1;
      r_sram_oe_n    <= 1'b1;
      r_sram_we_n    <= 1'b1;
      r_sram_dout    <= 32'h0000_0000;
      r_sram_dout_en <= 1'b0;
    end else begin
      // Pipeline advances: both requests retire together. A completing access below overrides.
      if (!w_stall) begin
        r_mem_served <= 1'b0;
        r_if_served  <= 1'b0;
      end
      case (r_state)
        S_IDLE: begin
          if (w_mem_pend && mem_we_i) begin
            r_state        <= S_WR1;
            r_owner_mem    <= 1'b1;
            r_sram_addr    <= mem_addr_i[ADDR_W+1:2];
            r_sram_dout    <= mem_data_i;
            r_sram_be_n    <= ~mem_sel_i;
            r_sram_dout_en <= 1'b1;
            r_sram_ce_n    <= 1'b0;
            r_sram_oe_n    <= 1'b1;
            r_sram_we_n    <= 1'b1;
          end else if (w_mem_pend) begin
            // Loads read the full word; the pipeline picks its lanes from mem_data_o.
            r_state     <= S_RD1;
            r_owner_mem <= 1'b1;
            r_sram_addr <= mem_addr_i[ADDR_W+1:2];
            r_sram_be_n <= 4'b0000;
            r_sram_ce_n <= 1'b0;
            r_sram_oe_n <= 1'b0;
            r_sram_we_n <= 1'b1;
          end else if (w_if_pend) begin
            r_state     <= S_RD1;
            r_owner_mem <= 1'b0;
            r_sram_addr <= if_addr_i[ADDR_W+1:2];
            r_sram_be_n <= 4'b0000;
            r_sram_ce_n <= 1'b0;
            r_sram_oe_n <= 1'b0;
            r_sram_we_n <= 1'b1;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RD1, S_RDW: begin
          if (w_rd_last) begin
            r_state     <= S_RD2;
            r_sram_ce_n <= 1'b1;
            r_sram_oe_n <= 1'b1;
            r_sram_be_n <= 4'hF;
            if (r_owner_mem) begin
              r_mem_data   <= sram_din_i;
              r_mem_served <= 1'b1;
            end else begin
              r_if_data   <= sram_din_i;
              r_if_served <= 1'b1;
            end
          end else begin
            r_state <= S_RDW;
          end
        end
        S_RD2: begin
          r_state <= S_IDLE;
        end
        S_WR1: begin
          r_state     <= S_WR2;
          r_sram_we_n <= 1'b0;
        end
        S_WR2, S_WRW: begin
          if (w_wr_last) begin
            r_state      <= S_WR3;
            r_sram_we_n  <= 1'b1;
            r_mem_served <= 1'b1;
          end else begin
            r_state <= S_WRW;
          end
        end
        S_WR3: begin
          r_state        <= S_IDLE;
          r_sram_ce_n    <= 1'b1;
          r_sram_oe_n    <= 1'b1;
          r_sram_we_n    <= 1'b1;
          r_sram_be_n    <= 4'hF;
          r_sram_dout_en <= 1'b0;
        end
        default: begin
          r_state        <= S_IDLE;
          r_sram_ce_n    <= 1'b1;
          r_sram_oe_n    <= 1'b1;
          r_sram_we_n    <= 1'b1;
          r_sram_be_n    <= 4'hF;
          r_sram_dout_en <= 1'b0;
        end
      endcase
    end
  end

  assign stall_o        = w_stall;
  assign if_data_o      = r_if_data;
  assign mem_data_o     = r_mem_data;
  assign sram_addr_o    = r_sram_addr;
  assign sram_be_n_o    = r_sram_be_n;
  assign sram_ce_n_o    = r_sram_ce_n;
  assign sram_oe_n_o    = r_sram_oe_n;
  assign sram_we_n_o    = r_sram_we_n;
  assign sram_dout_o    = r_sram_dout;
  assign sram_dout_en_o = r_sram_dout_en;

endmodule
